// File: rtl/byte_pack_pkg.sv
// Shared FunSel operation encoding for the byte pack register.
package byte_pack_pkg;

  typedef enum logic [2:0] {
    FS_SEXT     = 3'b000,
    FS_ZEXT     = 3'b001,
    FS_SHL      = 3'b010,
    FS_SHR      = 3'b011,
    FS_PACK_LSB = 3'b100,
    FS_PACK_MSB = 3'b101,
    FS_ABORT    = 3'b110,
    FS_CLR      = 3'b111
  } fun_sel_e;

  function automatic logic is_pack(input fun_sel_e fs);
    return (fs == FS_PACK_LSB) || (fs == FS_PACK_MSB);
  endfunction

endpackage

// File: rtl/byte_pack_counter.sv
// Lane counter and word-completion detect with the out_valid/out_ready handshake.
module byte_pack_counter #(
  parameter int WORD_BYTES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        accept_i,
  input  logic                        clear_i,
  input  logic                        out_ready_i,
  output logic                        in_ready_o,
  output logic                        out_valid_o,
  output logic [$clog2(WORD_BYTES):0] cnt_o
);

  localparam int CNT_W = $clog2(WORD_BYTES) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_BYTES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;

  assign in_ready_o = !(valid_q && !out_ready_i);

  always_comb begin
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (valid_q && out_ready_i) valid_d = 1'b0;
    if (clear_i) begin
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (accept_i) begin
      // the completing byte re-arms the count in the same update
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid_o = valid_q;
  assign cnt_o       = cnt_q;

endmodule

// File: rtl/byte_pack_register.sv
// Byte load/shift/pack register with a ready/valid word output.
// Optional BYTE_PACK_PARITY_EN adds a registered even-parity output of Q.
module byte_pack_register
  import byte_pack_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int WORD_BYTES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          E,
  input  logic [2:0]                    FunSel,
  input  logic [DATA_W-1:0]             I,
  output logic                          in_ready,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [DATA_W*WORD_BYTES-1:0]  Q,
  output logic [$clog2(WORD_BYTES):0]   cnt
`ifdef BYTE_PACK_PARITY_EN
  ,
  output logic                          out_parity
`endif
);

  localparam int WORD_W = DATA_W * WORD_BYTES;

  fun_sel_e fs;
  logic     pack_op, accept, clear;

  assign fs      = fun_sel_e'(FunSel);
  assign pack_op = is_pack(fs);
  assign accept  = E && pack_op && in_ready;
  assign clear   = E && !pack_op;

  logic [WORD_W-1:0] q_q, q_d, shl_w, shr_w;

  assign shl_w = {q_q[WORD_W-DATA_W-1:0], I};
  assign shr_w = {I, q_q[WORD_W-1:DATA_W]};

  always_comb begin
    q_d = q_q;
    if (E) begin
      case (fs)
        FS_SEXT:     q_d = {{(WORD_W-DATA_W){I[DATA_W-1]}}, I};
        FS_ZEXT:     q_d = {{(WORD_W-DATA_W){1'b0}}, I};
        FS_SHL:      q_d = shl_w;
        FS_SHR:      q_d = shr_w;
        FS_PACK_LSB: if (in_ready) q_d = shr_w;
        FS_PACK_MSB: if (in_ready) q_d = shl_w;
        FS_CLR:      q_d = '0;
        default:     q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign Q = q_q;

  byte_pack_counter #(
    .WORD_BYTES (WORD_BYTES)
  ) u_counter (
    .clk         (clk),
    .rst         (rst),
    .accept_i    (accept),
    .clear_i     (clear),
    .out_ready_i (out_ready),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .cnt_o       (cnt)
  );

`ifdef BYTE_PACK_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= ^q_d;
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_byte_pack_register.sv
// Self-checking bench for byte_pack_register (DATA_W=8, WORD_BYTES=4).
module tb_byte_pack_register;

  logic        clk = 1'b0;
  logic        rst;
  logic        E;
  logic [2:0]  FunSel;
  logic [7:0]  I;
  logic        in_ready;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] Q;
  logic [2:0]  cnt;
`ifdef BYTE_PACK_PARITY_EN
  logic        out_parity;
`endif

  byte_pack_register #(.DATA_W(8), .WORD_BYTES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .E         (E),
    .FunSel    (FunSel),
    .I         (I),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .Q         (Q),
    .cnt       (cnt)
`ifdef BYTE_PACK_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // reference model: register value, bytes held in the open word, word-pending flag
  logic [31:0] m_q;
  int          m_cnt;
  bit          m_valid;
  bit          m_in_ready;
  logic        pre_in_ready;

  task automatic model_reset();
    m_q = 32'h0; m_cnt = 0; m_valid = 0;
  endtask

  // drive one clock with the given inputs and advance the model; returns at posedge+1
  task automatic cycle(input bit e, input logic [2:0] fs, input logic [7:0] b, input bit ordy);
    E = e; FunSel = fs; I = b; out_ready = ordy;
    #2;
    pre_in_ready = in_ready;
    m_in_ready   = !(m_valid && !ordy);
    @(posedge clk);
    if (m_valid && ordy) m_valid = 0;
    if (e) begin
      if (fs == 3'd4 || fs == 3'd5) begin
        if (m_in_ready) begin
          if (fs == 3'd4) m_q = (m_q >> 8) | (32'(b) << 24);
          else            m_q = (m_q << 8) | 32'(b);
          m_cnt = m_cnt + 1;
          if (m_cnt == 4) begin
            m_cnt = 0; m_valid = 1;
          end
        end
      end else begin
        case (fs)
          3'd0: m_q = (b >= 8'd128) ? (32'hFFFF_FF00 + 32'(b)) : 32'(b);
          3'd1: m_q = 32'(b);
          3'd2: m_q = (m_q << 8) | 32'(b);
          3'd3: m_q = (m_q >> 8) | (32'(b) << 24);
          3'd7: m_q = 32'h0;
          default: ;
        endcase
        m_cnt = 0; m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; E = 1'b0; FunSel = 3'd0; I = 8'h00; out_ready = 1'b0;
    #3;
    n_checks++; if (Q !== 32'h0) begin n_err++; $display("FAIL reset_q got %h exp %h", Q, 32'h0); end
    n_checks++; if (cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
    n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_direct_ops();
    cycle(1, 3'd0, 8'h80, 0);
    n_checks++; if (Q !== 32'hFFFF_FF80) begin n_err++; $display("FAIL sext_q got %h exp ffffff80", Q); end
    n_checks++; if (out_valid !== 1'b0 || cnt !== 3'd0) begin n_err++; $display("FAIL sext_ctl got valid=%b cnt=%0d exp 0/0", out_valid, cnt); end
    cycle(1, 3'd1, 8'h80, 0);
    n_checks++; if (Q !== 32'h0000_0080) begin n_err++; $display("FAIL zext_q got %h exp 00000080", Q); end
    cycle(1, 3'd2, 8'h12, 0);
    n_checks++; if (Q !== 32'h0000_8012) begin n_err++; $display("FAIL shl_q got %h exp 00008012", Q); end
    cycle(1, 3'd3, 8'h34, 0);
    n_checks++; if (Q !== 32'h3400_0080) begin n_err++; $display("FAIL shr_q got %h exp 34000080", Q); end
    cycle(0, 3'd7, 8'h00, 0);
    n_checks++; if (Q !== 32'h3400_0080) begin n_err++; $display("FAIL e0_hold_q got %h exp 34000080", Q); end
    cycle(1, 3'd7, 8'h99, 0);
    n_checks++; if (Q !== 32'h0) begin n_err++; $display("FAIL clr_q got %h exp 0", Q); end
  endtask

  task automatic test_pack_lsb();
    logic [7:0] bytes [4];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    for (int k = 0; k < 4; k++) begin
      cycle(1, 3'd4, bytes[k], 1);
      if (k < 3) begin
        n_checks++; if (cnt !== 3'(k + 1) || out_valid !== 1'b0) begin n_err++; $display("FAIL lsb_partial%0d got cnt=%0d valid=%b exp cnt=%0d valid=0", k, cnt, out_valid, k + 1); end
      end
    end
    n_checks++; if (Q !== 32'h4433_2211) begin n_err++; $display("FAIL lsb_word got %h exp 44332211", Q); end
    n_checks++; if (out_valid !== 1'b1 || cnt !== 3'd0) begin n_err++; $display("FAIL lsb_done got valid=%b cnt=%0d exp 1/0", out_valid, cnt); end
    cycle(0, 3'd4, 8'h00, 1);
    n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lsb_one_cycle got valid=%b exp 0", out_valid); end
    n_checks++; if (Q !== 32'h4433_2211) begin n_err++; $display("FAIL lsb_hold got %h exp 44332211", Q); end
  endtask

  task automatic test_pack_msb_stall();
    cycle(1, 3'd5, 8'h11, 0);
    cycle(1, 3'd5, 8'h22, 0);
    cycle(1, 3'd5, 8'h33, 0);
    cycle(1, 3'd5, 8'h44, 0);
    n_checks++; if (Q !== 32'h1122_3344) begin n_err++; $display("FAIL msb_word got %h exp 11223344", Q); end
    n_checks++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL msb_valid got %b exp 1", out_valid); end
    for (int k = 0; k < 2; k++) begin
      cycle(1, 3'd5, 8'h55, 0);
      n_checks++; if (pre_in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready got %b exp 0", pre_in_ready); end
      n_checks++; if (Q !== 32'h1122_3344 || cnt !== 3'd0 || out_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold got q=%h cnt=%0d valid=%b exp 11223344/0/1", Q, cnt, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    cycle(1, 3'd5, 8'hAA, 1);
    n_checks++; if (pre_in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got %b exp 1", pre_in_ready); end
    n_checks++; if (out_valid !== 1'b0 || cnt !== 3'd1) begin n_err++; $display("FAIL b2b_ctl got valid=%b cnt=%0d exp 0/1", out_valid, cnt); end
    n_checks++; if (Q !== 32'h2233_44AA) begin n_err++; $display("FAIL b2b_q got %h exp 223344aa", Q); end
  endtask

  task automatic test_abort();
    cycle(1, 3'd5, 8'hBB, 0);
    cycle(1, 3'd5, 8'hCC, 0);
    n_checks++; if (cnt !== 3'd3) begin n_err++; $display("FAIL abort_pre_cnt got %0d exp 3", cnt); end
    cycle(1, 3'd6, 8'hEE, 0);
    n_checks++; if (cnt !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL abort_ctl got cnt=%0d valid=%b exp 0/0", cnt, out_valid); end
    n_checks++; if (Q !== 32'h44AA_BBCC) begin n_err++; $display("FAIL abort_q got %h exp 44aabbcc", Q); end
`ifdef BYTE_PACK_PARITY_EN
    cycle(1, 3'd1, 8'h07, 0);
    n_checks++; if (out_parity !== 1'b1) begin n_err++; $display("FAIL parity7 got %b exp 1", out_parity); end
    cycle(1, 3'd1, 8'h03, 0);
    n_checks++; if (out_parity !== 1'b0) begin n_err++; $display("FAIL parity3 got %b exp 0", out_parity); end
`endif
  endtask

  task automatic test_async_reset();
    cycle(1, 3'd7, 8'h00, 0);
    cycle(1, 3'd4, 8'h01, 0);
    cycle(1, 3'd4, 8'h02, 0);
    E = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (Q !== 32'h0 || cnt !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL async_rst got q=%h cnt=%0d valid=%b exp 0/0/0", Q, cnt, out_valid); end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    model_reset();
    cycle(1, 3'd4, 8'h01, 0);
    cycle(1, 3'd4, 8'h02, 0);
    cycle(1, 3'd4, 8'h03, 0);
    n_checks++; if (cnt !== 3'd3 || out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_partial got cnt=%0d valid=%b exp 3/0", cnt, out_valid); end
    cycle(1, 3'd4, 8'h04, 0);
    n_checks++; if (Q !== 32'h0403_0201 || out_valid !== 1'b1 || cnt !== 3'd0) begin n_err++; $display("FAIL post_rst_word got q=%h valid=%b cnt=%0d exp 04030201/1/0", Q, out_valid, cnt); end
    cycle(1, 3'd7, 8'h00, 1);
  endtask

  task automatic test_random();
    bit         e;
    logic [2:0] fs;
    for (int n = 0; n < 400; n++) begin
      e  = ($urandom_range(0, 7) != 0);
      fs = ($urandom_range(0, 4) != 0) ? 3'(4 + $urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      cycle(e, fs, 8'($urandom), bit'($urandom_range(0, 2) != 0));
      n_checks++; if (pre_in_ready !== m_in_ready) begin n_err++; $display("FAIL rnd_in_ready[%0d] got %b exp %b", n, pre_in_ready, m_in_ready); end
      n_checks++; if (Q !== m_q) begin n_err++; $display("FAIL rnd_q[%0d] got %h exp %h", n, Q, m_q); end
      n_checks++; if (cnt !== 3'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", n, cnt, m_cnt); end
      n_checks++; if (out_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid[%0d] got %b exp %b", n, out_valid, m_valid); end
`ifdef BYTE_PACK_PARITY_EN
      n_checks++; if (out_parity !== ^m_q) begin n_err++; $display("FAIL rnd_parity[%0d] got %b exp %b", n, out_parity, ^m_q); end
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_direct_ops();
    test_pack_lsb();
    test_pack_msb_stall();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/byte_pack_register.md
BYTE_PACK_REGISTER -- requirements
Module: byte_pack_register

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning input byte width in bits.
REQ-002 SHALL have parameter WORD_BYTES, default 4, meaning lanes per word (legal range 2..8); WORD_W = DATA_W*WORD_BYTES.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port E  input  1  byte strobe/enable.
REQ-006 SHALL have port FunSel  input  3  operation select (encoding in REQ-012).
REQ-007 SHALL have port I  input  DATA_W  input byte.
REQ-008 SHALL have port in_ready  output  1  high when a pack-mode byte can be accepted.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the packed word.
REQ-010 SHALL have port out_valid  output  1  packed word complete on Q.
REQ-011 SHALL have ports Q  output  WORD_W  register contents, and cnt  output  $clog2(WORD_BYTES)+1  bytes held in the current pack.

Function
REQ-012 FunSel decode with E=1: 000 sign-extend I into Q; 001 zero-extend I; 010 Q<={Q[WORD_W-DATA_W-1:0],I}; 011 Q<={I,Q[WORD_W-1:DATA_W]}; 100 pack LSB-first (as 011); 101 pack MSB-first (as 010); 110 abort pack; 111 clear Q.
REQ-013 Direct ops (000-011, 111) SHALL execute in one cycle whenever E=1, ignore in_ready, set cnt<=0 and out_valid<=0.
REQ-014 Pack byte SHALL be accepted only when E=1, FunSel in {100,101} and in_ready=1; accepted byte SHALL increment cnt.
REQ-015 Acceptance of the byte making cnt reach WORD_BYTES SHALL set out_valid=1 on the next cycle and reset cnt to 0 in the same update.
REQ-016 in_ready SHALL equal !(out_valid && !out_ready) (combinational); while stalled, Q and cnt SHALL hold.
REQ-017 A word transfer SHALL occur when out_valid && out_ready; out_valid SHALL then drop unless the same edge completes another word.
REQ-018 Transfer and a new pack byte on the same edge SHALL both take effect: word consumed, new byte loaded, cnt=1.
REQ-019 FunSel=110 with E=1 SHALL set cnt<=0 and out_valid<=0, keeping Q.
REQ-020 Switching pack direction mid-word SHALL continue counting; byte order is the user's responsibility.
REQ-021 E=0 SHALL hold Q, cnt, out_valid.

Reset
REQ-022 rst=1 SHALL immediately force Q=0, cnt=0, out_valid=0, independent of clk.
REQ-023 Reset mid-pack SHALL discard partial bytes; first byte after release SHALL start a new word.

Configuration
REQ-024 With BYTE_PACK_PARITY_EN defined, an extra output out_parity (1 bit) SHALL carry registered even parity (XOR-reduce) of the next Q value, updated with Q, reset 0.
REQ-025 Without BYTE_PACK_PARITY_EN, the port and its logic SHALL be absent; all other behaviour unchanged.

Structure
REQ-026 Package byte_pack_pkg SHALL hold the FunSel enum typedef (FS_SEXT, FS_ZEXT, FS_SHL, FS_SHR, FS_PACK_LSB, FS_PACK_MSB, FS_ABORT, FS_CLR).
REQ-027 Lane counter and completion detect SHALL be a sub-module byte_pack_counter; shift/load datapath stays in the top.

Verification (DATA_W=8, WORD_BYTES=4)
REQ-028 E=1, FunSel=000, I=8'h80 -> Q=32'hFFFF_FF80, out_valid=0, cnt=0.
REQ-029 FunSel=100, bytes 11,22,33,44 on consecutive cycles, out_ready=1 -> Q=32'h4433_2211, out_valid high exactly one cycle.
REQ-030 FunSel=101, bytes 11,22,33,44, out_ready=0 -> Q=32'h1122_3344, out_valid held, in_ready=0, fifth byte 55 ignored until out_ready=1.
REQ-031 Word valid, out_ready=1 and pack byte AA same edge -> out_valid=0, cnt=1, Q low byte AA path correct.
REQ-032 rst pulsed asynchronously after 2 pack bytes -> Q=0, cnt=0 before next clk; next 4 bytes form a full word.
REQ-033 FunSel=110 after 3 pack bytes -> cnt=0, Q unchanged; with BYTE_PACK_PARITY_EN, Q=32'h0000_0007 -> out_parity=1.
